// File: rtl/control_decode_stage.sv
// RV32I control decode feeding a DEPTH-entry output buffer.
// Define CTRL_ILLEGAL_DETECT_EN to flag undecodable encodings on illegal_instr.
module control_decode_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 8,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instruction,
  input  logic [XLEN-1:0]     pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic                regfile_wr_en,
  output logic                branch_control,
  output logic                jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                rs1_select,
  output logic                rs2_select,
  output logic [2:0]          alu_select,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                illegal_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_ALUI  = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_ALU   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  localparam logic [2:0] SEL_NOP = 3'd0;
  localparam logic [2:0] SEL_ARI = 3'd1;
  localparam logic [2:0] SEL_MEM = 3'd2;
  localparam logic [2:0] SEL_BR  = 3'd3;
  localparam logic [2:0] SEL_JMP = 3'd4;
  localparam logic [2:0] SEL_UP  = 3'd5;

  localparam logic [ALU_OP_W-1:0] A_NOP   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] A_ADD   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] A_SUB   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] A_SLL   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] A_SLT   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] A_SLTU  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] A_XOR   = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] A_SRL   = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] A_SRA   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] A_OR    = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] A_AND   = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] A_ADDI  = ALU_OP_W'(11);
  localparam logic [ALU_OP_W-1:0] A_SLLI  = ALU_OP_W'(12);
  localparam logic [ALU_OP_W-1:0] A_SLTI  = ALU_OP_W'(13);
  localparam logic [ALU_OP_W-1:0] A_SLTIU = ALU_OP_W'(14);
  localparam logic [ALU_OP_W-1:0] A_XORI  = ALU_OP_W'(15);
  localparam logic [ALU_OP_W-1:0] A_SRLI  = ALU_OP_W'(16);
  localparam logic [ALU_OP_W-1:0] A_SRAI  = ALU_OP_W'(17);
  localparam logic [ALU_OP_W-1:0] A_ORI   = ALU_OP_W'(18);
  localparam logic [ALU_OP_W-1:0] A_ANDI  = ALU_OP_W'(19);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     imm;
    logic                wr_en;
    logic                br;
    logic                jmp;
    logic                mrd;
    logic                mwr;
    logic                m2r;
    logic                s1;
    logic                s2;
    logic [2:0]          asel;
    logic [ALU_OP_W-1:0] aop;
    logic                ill;
  } entry_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm32;
  logic        bad;
  entry_t      dec;

  assign opc   = instruction[6:0];
  assign f3    = instruction[14:12];
  assign f7    = instruction[31:25];
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25],
                  instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31],
                  instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    imm32     = '0;
    bad       = 1'b0;
    dec.pc    = pc;
    dec.rd    = instruction[11:7];
    dec.rs1   = instruction[19:15];
    dec.rs2   = instruction[24:20];
    dec.aop   = A_ADD;
    case (opc)
      OP_ALU: begin
        dec.wr_en = 1'b1;
        dec.asel  = SEL_ARI;
        bad = !(f7 == 7'h00 ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        case (f3)
          3'd0: dec.aop = f7[5] ? A_SUB : A_ADD;
          3'd1: dec.aop = A_SLL;
          3'd2: dec.aop = A_SLT;
          3'd3: dec.aop = A_SLTU;
          3'd4: dec.aop = A_XOR;
          3'd5: dec.aop = f7[5] ? A_SRA : A_SRL;
          3'd6: dec.aop = A_OR;
          3'd7: dec.aop = A_AND;
        endcase
      end
      OP_ALUI: begin
        dec.wr_en = 1'b1;
        dec.s2    = 1'b1;
        dec.asel  = SEL_ARI;
        imm32     = imm_i;
        case (f3)
          3'd0: dec.aop = A_ADDI;
          3'd1: begin
            dec.aop = A_SLLI;
            bad     = f7 != 7'h00;
          end
          3'd2: dec.aop = A_SLTI;
          3'd3: dec.aop = A_SLTIU;
          3'd4: dec.aop = A_XORI;
          3'd5: begin
            dec.aop = instruction[30] ? A_SRAI : A_SRLI;
            bad     = !(f7 == 7'h00 || f7 == 7'h20);
          end
          3'd6: dec.aop = A_ORI;
          3'd7: dec.aop = A_ANDI;
        endcase
      end
      OP_LOAD: begin
        {dec.wr_en, dec.mrd, dec.m2r, dec.s2} = 4'b1111;
        dec.asel = SEL_MEM;
        imm32    = imm_i;
        bad      = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      OP_STORE: begin
        {dec.mwr, dec.s2} = 2'b11;
        dec.asel = SEL_MEM;
        imm32    = imm_s;
        bad      = f3 > 3'd2;
      end
      OP_BR: begin
        dec.br   = 1'b1;
        dec.asel = SEL_BR;
        dec.aop  = A_SUB;
        imm32    = imm_b;
        bad      = f3 == 3'd2 || f3 == 3'd3;
      end
      OP_JAL: begin
        {dec.jmp, dec.wr_en, dec.s1, dec.s2} = 4'b1111;
        dec.asel = SEL_JMP;
        imm32    = imm_j;
      end
      OP_JALR: begin
        {dec.jmp, dec.wr_en, dec.s2} = 3'b111;
        dec.asel = SEL_JMP;
        imm32    = imm_i;
        bad      = f3 != 3'd0;
      end
      // LUI reads x0 as its rs1 operand so the adder yields the immediate
      OP_LUI: begin
        {dec.wr_en, dec.s2} = 2'b11;
        dec.rs1  = 5'd0;
        dec.asel = SEL_UP;
        imm32    = imm_u;
      end
      OP_AUIPC: begin
        {dec.wr_en, dec.s1, dec.s2} = 3'b111;
        dec.asel = SEL_UP;
        imm32    = imm_u;
      end
      default: bad = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    if (bad) begin
      dec.imm   = '0;
      {dec.wr_en, dec.br, dec.jmp, dec.mrd} = 4'b0;
      {dec.mwr, dec.m2r, dec.s1, dec.s2} = 4'b0;
      dec.asel  = SEL_NOP;
      dec.aop   = A_NOP;
`ifdef CTRL_ILLEGAL_DETECT_EN
      dec.ill   = 1'b1;
`else
      dec.ill   = 1'b0;
`endif
    end
    if (dec.rd == 5'd0) dec.wr_en = 1'b0;
  end

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign in_ready  = !rst && (count != CW'(DEPTH));
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head           = mem[rd_ptr];
  assign out_pc         = head.pc;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_imm        = head.imm;
  assign regfile_wr_en  = head.wr_en;
  assign branch_control = head.br;
  assign jump           = head.jmp;
  assign mem_read       = head.mrd;
  assign mem_write      = head.mwr;
  assign mem_to_reg     = head.m2r;
  assign rs1_select     = head.s1;
  assign rs2_select     = head.s2;
  assign alu_select     = head.asel;
  assign alu_operation  = head.aop;
  assign illegal_instr  = out_valid && head.ill;

endmodule

// File: tb/tb_control_decode_stage.sv
// Bench for control_decode_stage: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_control_decode_stage;

  localparam int D = 2;
`ifdef CTRL_ILLEGAL_DETECT_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  localparam logic [7:0] A_ADD = 8'd1, A_SUB = 8'd2, A_SRA = 8'd8;
  localparam logic [7:0] A_SRAI = 8'd17, A_ANDI = 8'd19;
  localparam logic [7:0] R_OP[8] = '{1, 3, 4, 5, 6, 7, 9, 10};
  localparam logic [7:0] I_OP[8] = '{11, 12, 13, 14, 15, 16, 18, 19};
  localparam logic [6:0] OPS[10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                                     7'h37, 7'h63, 7'h67, 7'h6F, 7'h7F};

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] instruction = 0;
  logic [31:0] pc = 0;
  logic        flush = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        regfile_wr_en, branch_control, jump, mem_read;
  logic        mem_write, mem_to_reg, rs1_select, rs2_select;
  logic [2:0]  alu_select;
  logic [7:0]  alu_operation;
  logic        illegal_instr;

  control_decode_stage #(.XLEN(32), .ALU_OP_W(8), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .regfile_wr_en(regfile_wr_en),
    .branch_control(branch_control), .jump(jump),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .rs1_select(rs1_select),
    .rs2_select(rs2_select), .alu_select(alu_select),
    .alu_operation(alu_operation), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic wr, br, jmp, mr, mw, m2r, s1, s2;
    logic [2:0]  asel;
    logic [7:0]  aop;
    logic        ill;
  } bnd_t;

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  aop;
    logic [31:0] imm;
    logic [8:0]  ctl;
  } vec_t;

  int errors = 0;
  int checks = 0;
  bnd_t q[$];

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic bnd_t act();
    bnd_t a;
    a = '{out_pc, out_rd, out_rs1, out_rs2, out_imm, regfile_wr_en,
          branch_control, jump, mem_read, mem_write, mem_to_reg,
          rs1_select, rs2_select, alu_select, alu_operation,
          illegal_instr};
    return a;
  endfunction

  function automatic logic [8:0] ctl();
    return {regfile_wr_en, branch_control, jump, mem_read, mem_write,
            mem_to_reg, rs1_select, rs2_select, illegal_instr};
  endfunction

  function automatic bnd_t model(input logic [31:0] i,
                                 input logic [31:0] p);
    bnd_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    int v;
    bit ok;
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1;
    v = 0;
    e = '0;
    e.pc = p;
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.aop = A_ADD;
    case (i[6:0])
      7'h33: begin
        ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.aop = f7 == 7'h20 ? (f3 == 0 ? A_SUB : A_SRA) : R_OP[f3];
        e.wr = 1; e.asel = 1;
      end
      7'h13: begin
        ok = !(f3 == 1 && f7 != 0) &&
             !(f3 == 5 && f7 != 0 && f7 != 7'h20);
        e.aop = (f3 == 5 && i[30]) ? A_SRAI : I_OP[f3];
        e.wr = 1; e.s2 = 1; e.asel = 1;
        v = $signed(i[31:20]);
      end
      7'h03: begin
        ok = f3 != 3 && f3 < 6;
        e.wr = 1; e.mr = 1; e.m2r = 1; e.s2 = 1; e.asel = 2;
        v = $signed(i[31:20]);
      end
      7'h23: begin
        ok = f3 <= 2;
        e.mw = 1; e.s2 = 1; e.asel = 2;
        v = $signed({i[31:25], i[11:7]});
      end
      7'h63: begin
        ok = f3 != 2 && f3 != 3;
        e.br = 1; e.asel = 3; e.aop = A_SUB;
        v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      end
      7'h6F: begin
        e.jmp = 1; e.wr = 1; e.s1 = 1; e.s2 = 1; e.asel = 4;
        v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      end
      7'h67: begin
        ok = f3 == 0;
        e.jmp = 1; e.wr = 1; e.s2 = 1; e.asel = 4;
        v = $signed(i[31:20]);
      end
      7'h37: begin
        e.wr = 1; e.s2 = 1; e.asel = 5; e.rs1 = 0;
        v = {i[31:12], 12'h000};
      end
      7'h17: begin
        e.wr = 1; e.s1 = 1; e.s2 = 1; e.asel = 5;
        v = {i[31:12], 12'h000};
      end
      default: ok = 0;
    endcase
    e.imm = v;
    if (!ok) begin
      e = '{p, i[11:7], i[19:15], i[24:20], 32'h0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, ILL};
    end
    if (e.rd == 0) e.wr = 0;
    return e;
  endfunction

  vec_t tv[13];

  initial begin
    tv[0]  = '{32'h003100B3, A_ADD,  32'h0,        9'b100000000};
    tv[1]  = '{32'hFFF0F093, A_ANDI, 32'hFFFFFFFF, 9'b100000010};
    tv[2]  = '{32'h40310133, A_SUB,  32'h0,        9'b100000000};
    tv[3]  = '{32'h40335293, A_SRAI, 32'h00000403, 9'b100000010};
    tv[4]  = '{32'h0080A203, A_ADD,  32'h8,        9'b100101010};
    tv[5]  = '{32'hFE20AE23, A_ADD,  32'hFFFFFFFC, 9'b000010010};
    tv[6]  = '{32'hFE208CE3, A_SUB,  32'hFFFFFFF8, 9'b010000000};
    tv[7]  = '{32'h010000EF, A_ADD,  32'h10,       9'b101000110};
    tv[8]  = '{32'h123451B7, A_ADD,  32'h12345000, 9'b100000010};
    tv[9]  = '{32'h00001197, A_ADD,  32'h1000,     9'b100000110};
    tv[10] = '{32'hFFFFFFFF, 8'd0,   32'h0,        {8'b0, ILL}};
    tv[11] = '{32'h00208033, A_ADD,  32'h0,        9'b000000000};
    tv[12] = '{32'h004100E7, A_ADD,  32'h4,        9'b101000010};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_illegal", illegal_instr, 0);
    rst = 0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    out_ready = 1;
    foreach (tv[k]) begin
      @(negedge clk);
      in_valid = 1;
      instruction = tv[k].ins;
      pc = 32'h1000 + 4 * k;
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("tv%0d_valid", k), out_valid, 1);
      chk($sformatf("tv%0d_aop", k), alu_operation, tv[k].aop);
      chk($sformatf("tv%0d_imm", k), out_imm, tv[k].imm);
      chk($sformatf("tv%0d_ctl", k), ctl(), tv[k].ctl);
      chk($sformatf("tv%0d_rd", k), out_rd, tv[k].ins[11:7]);
    end
    @(negedge clk);
    chk("tv_drained", out_valid, 0);

    // fill with out_ready low, stall, then drain in order (twice for wrap)
    for (int r = 0; r < 2; r++) begin
      out_ready = 0;
      for (int k = 0; k < D; k++) begin
        @(negedge clk);
        chk("fill_ready", in_ready, 1);
        in_valid = 1;
        instruction = {20'h00310, 5'(k + 1), 7'h33};
      end
      @(negedge clk);
      in_valid = 0;
      chk("full_ready", in_ready, 0);
      chk("full_valid", out_valid, 1);
      chk("head_rd", out_rd, 1);
      @(negedge clk);
      chk("stall_rd", out_rd, 1);
      chk("stall_valid", out_valid, 1);
      out_ready = 1;
      for (int k = 1; k < D; k++) begin
        @(negedge clk);
        chk("drain_rd", out_rd, 5'(k + 1));
      end
      @(negedge clk);
      chk("drain_empty", out_valid, 0);
    end

    // flush with 1 and with 2 buffered entries; concurrent push is lost
    for (int n = 1; n <= 2; n++) begin
      out_ready = 0;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        in_valid = 1;
        instruction = 32'h003100B3;
      end
      @(negedge clk);
      instruction = 32'h00208133;
      flush = 1;
      @(negedge clk);
      flush = 0;
      in_valid = 0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      @(negedge clk);
      chk("flush_lost", out_valid, 0);
    end

    // asynchronous reset with one entry buffered
    @(negedge clk);
    in_valid = 1;
    instruction = 32'h003100B3;
    @(negedge clk);
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_ill", illegal_instr, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("rel_ready", in_ready, 1);
    @(negedge clk);
    chk("rel_no_pulse", out_valid, 0);

    // random traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      bit do_push;
      @(negedge clk);
      chk("rnd_ready", in_ready, q.size() < D);
      chk("rnd_valid", out_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd_bundle", act(), q[0]);
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      pc = $urandom;
      instruction = $urandom;
      if ($urandom % 2) instruction[31:25] = ($urandom % 2) ? 7'h20 : 7'h0;
      instruction[6:0] = OPS[$urandom % 10];
      do_push = in_valid && q.size() < D;
      if (flush) q.delete();
      else begin
        if (out_ready && q.size() != 0) void'(q.pop_front());
        if (do_push) q.push_back(model(instruction, pc));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_decode_stage.md
CONTROL_DECODE_STAGE -- requirements
Module: control_decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width of pc and imm.
REQ-002 Parameter ALU_OP_W, default 8: width of alu_operation; encodings from isa.sv ALU_OPERATIONS_* macros.
REQ-003 Parameter DEPTH, default 2: output buffer entries; legal values 1..4.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: reset, asynchronous assert, active-high.
REQ-006 in_valid  in  1: instruction/pc valid.
REQ-007 in_ready  out  1: stage can accept; equals "buffer not full".
REQ-008 instruction  in  32: raw RV32I instruction word.
REQ-009 pc  in  XLEN: instruction address, passed through unchanged.
REQ-010 flush  in  1: discard all buffered entries.
REQ-011 out_valid  out  1: head entry valid.
REQ-012 out_ready  in  1: consumer accepts head entry.
REQ-013 out_pc  out  XLEN; out_rd  out  5; out_rs1  out  5; out_rs2  out  5: head entry fields.
REQ-014 out_imm  out  XLEN: sign-extended immediate (I/S/B/U/J formats per opcode).
REQ-015 regfile_wr_en, branch_control, jump, mem_read, mem_write, mem_to_reg, rs1_select, rs2_select  out  1 each: head entry control bits.
REQ-016 alu_select  out  3; alu_operation  out  ALU_OP_W: head entry ALU controls.
REQ-017 illegal_instr  out  1: head entry carries an undecodable instruction.

Function
REQ-018 Decode is combinational on the input; the decoded bundle is written into a DEPTH-entry circular buffer on in_valid && in_ready.
REQ-019 Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1 at the earliest.
REQ-020 Head entry pops on out_valid && out_ready; outputs shall hold stable while out_valid && !out_ready.
REQ-021 Simultaneous push and pop when full is not allowed (in_ready=0); when empty, push then pop the following cycle; no combinational input-to-output path.
REQ-022 Occupancy counter width clog2(DEPTH+1); read/write pointers wrap modulo DEPTH.
REQ-023 OPCODE_ALU: regfile_wr_en=1, rs2_select=register, funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
REQ-024 OPCODE_ALUI: regfile_wr_en=1, rs2_select=imm; ANDI shall map to ALU_OPERATIONS_ANDI (never ADDI); SRLI/SRAI split on instruction[30].
REQ-025 LOAD: mem_read=1, mem_to_reg=1, regfile_wr_en=1, ALU ADD; STORE: mem_write=1, regfile_wr_en=0, ALU ADD, S-immediate.
REQ-026 BRANCH: branch_control=1, regfile_wr_en=0, ALU SUB, B-immediate; JAL/JALR: jump=1, regfile_wr_en=1; LUI/AUIPC: regfile_wr_en=1, rs1_select selects zero/pc respectively.
REQ-027 Any other opcode decodes to NOP bundle: all enables 0, alu_select=ALU_SELECT_NOP, alu_operation=ALU_OPERATIONS_NOP.
REQ-028 flush clears occupancy and both pointers next edge; out_valid=0 the following cycle; a push in the flush cycle is dropped.
REQ-029 Write to x0 (rd=0): regfile_wr_en forced 0.

Reset
REQ-030 While rst=1: out_valid=0, in_ready=0, occupancy=0, pointers=0, illegal_instr=0.
REQ-031 First cycle after rst deasserts: in_ready=1; entry contents need not be cleared.
REQ-032 Reset mid-transfer discards all buffered entries with no output pulse.

Configuration
REQ-033 Macro CTRL_ILLEGAL_DETECT_EN: when defined, unknown opcodes, bad funct3 and bad funct7 on ALU/SRxI set illegal_instr=1 with the NOP bundle.
REQ-034 When CTRL_ILLEGAL_DETECT_EN is undefined, illegal_instr is tied 0 and unknown encodings silently yield the NOP bundle.

Verification
REQ-035 Reset then push 0x003100B3 (add x1,x2,x3) -> next cycle out_valid=1, regfile_wr_en=1, alu_operation=ADD, out_rd=1.
REQ-036 Push 0xFFF0F093 (andi x1,x1,-1) -> alu_operation=ANDI, out_imm=0xFFFFFFFF, rs2_select=imm.
REQ-037 out_ready=0, push DEPTH instructions -> in_ready=0 after DEPTH accepts; release out_ready -> entries drain in order, pointers wrap.
REQ-038 Buffer holding 2 entries, assert flush with in_valid=1 -> out_valid=0 next cycle, pushed word lost.
REQ-039 Push 0xFFFFFFFF with CTRL_ILLEGAL_DETECT_EN defined -> illegal_instr=1, all enables 0; undefined -> illegal_instr=0, NOP bundle.
REQ-040 Assert rst mid-stream with 1 entry buffered -> out_valid=0 immediately (asynchronous), in_ready=1 one cycle after release.
